// File: rtl/scv_pkg.sv
// Shared types for the scv VRAM arbiter: grant tags carried down the access
// pipeline and the arbiter's top-level states.
package scv_pkg;

  typedef enum logic [1:0] {
    VGNT_NONE,
    VGNT_VID,
    VGNT_CPU,
    VGNT_CLR
  } vram_gnt_t;

  typedef enum logic {
    VARB_CLEAR,
    VARB_RUN
  } varb_state_t;

  // Wait counter must hold 0..maxwait without wrapping.
  function automatic int wait_cnt_width(input int maxwait);
    return $clog2(maxwait + 2);
  endfunction

endpackage

// File: rtl/vram_arb.sv
// Shares one single-port registered-read VRAM between video fetch (priority)
// and the CPU (bounded wait); zero-fills the RAM after reset or on request.
module vram_arb
  import scv_pkg::*;
#(
  parameter int            AW          = 12,
  parameter int            DW          = 8,
  parameter logic [DW-1:0] CLR_VAL     = '0,
  parameter int            CPU_MAXWAIT = 2
) (
  input  logic          CLK,
  input  logic          RESB,
  input  logic          CE,
  input  logic          V_REQ,
  input  logic          V_WE,
  input  logic [AW-1:0] V_A,
  input  logic [DW-1:0] V_DI,
  output logic [DW-1:0] V_DO,
  output logic          V_ACK,
  input  logic          C_REQ,
  input  logic          C_WE,
  input  logic [AW-1:0] C_A,
  input  logic [DW-1:0] C_DI,
  output logic [DW-1:0] C_DO,
  output logic          C_ACK,
  output logic          C_WAIT,
  output logic [AW-1:0] M_A,
  output logic [DW-1:0] M_DI,
  input  logic [DW-1:0] M_DO,
  output logic          M_nCE,
  output logic          M_nWE,
  input  logic          CLR_START,
  output logic          CLR_BUSY
);

  localparam int WCW = wait_cnt_width(CPU_MAXWAIT);

  varb_state_t    r_state, w_state_next;
  vram_gnt_t      r_gnt_q, r_gnt_qq, w_gnt;
  logic           r_we_q, r_we_qq, w_we;
  logic [AW-1:0]  r_cnt, w_cnt_next;
  logic [WCW-1:0] r_wait, w_wait_next;
  logic           r_clr_busy, w_clr_busy_next;
  logic [AW-1:0]  r_m_a, w_m_a;
  logic [DW-1:0]  r_m_di, w_m_di;
  logic           r_m_nce, r_m_nwe, w_m_ce, w_m_we;
  logic           r_v_ack, r_c_ack;
  logic [DW-1:0]  r_v_do, r_c_do;
  logic           w_v_elig, w_c_elig, w_c_busy, w_cpu_wins;

  assign w_v_elig   = V_REQ & CE;
  assign w_c_busy   = (r_gnt_q == VGNT_CPU) || (r_gnt_qq == VGNT_CPU);
  // An ACK still showing means C_REQ is the request just completed.
  assign w_c_elig   = C_REQ & ~w_c_busy & ~r_c_ack;
  assign w_cpu_wins = w_c_elig & (~w_v_elig | (r_wait >= WCW'(CPU_MAXWAIT)));

  always_comb begin
    w_state_next    = r_state;
    w_clr_busy_next = r_clr_busy;
    w_cnt_next      = r_cnt;
    w_wait_next     = r_wait;
    w_gnt           = VGNT_NONE;
    w_we            = 1'b0;
    w_m_ce          = 1'b0;
    w_m_we          = 1'b0;
    w_m_a           = r_m_a;
    w_m_di          = r_m_di;

    if (r_state == VARB_CLEAR) begin
      w_m_ce     = 1'b1;
      w_m_we     = 1'b1;
      w_m_a      = r_cnt;
      w_m_di     = CLR_VAL;
      w_cnt_next = r_cnt + AW'(1);
      // Video reads during a clear are answered with the fill value, no RAM cycle.
      if (w_v_elig) w_gnt = VGNT_CLR;
      if (&r_cnt) begin
        w_state_next    = VARB_RUN;
        w_clr_busy_next = 1'b0;
      end
    end else begin
      if (w_cpu_wins) begin
        w_gnt       = VGNT_CPU;
        w_we        = C_WE;
        w_m_ce      = 1'b1;
        w_m_we      = C_WE;
        w_m_a       = C_A;
        w_m_di      = C_DI;
        w_wait_next = '0;
      end else if (w_v_elig) begin
        w_gnt  = VGNT_VID;
        w_we   = V_WE;
        w_m_ce = 1'b1;
        w_m_we = V_WE;
        w_m_a  = V_A;
        w_m_di = V_DI;
        if (w_c_elig) w_wait_next = r_wait + WCW'(1);
      end
      if (CLR_START) begin
        w_state_next    = VARB_CLEAR;
        w_clr_busy_next = 1'b1;
        w_cnt_next      = '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      r_state    <= VARB_CLEAR;
      r_clr_busy <= 1'b1;
      r_cnt      <= '0;
      r_wait     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_clr_busy <= w_clr_busy_next;
      r_cnt      <= w_cnt_next;
      r_wait     <= w_wait_next;
    end
  end

  // RAM bus at t0, RAM latches at t1, DO/ACK registered at t2.
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      r_m_a    <= '0;
      r_m_di   <= '0;
      r_m_nce  <= 1'b1;
      r_m_nwe  <= 1'b1;
      r_gnt_q  <= VGNT_NONE;
      r_gnt_qq <= VGNT_NONE;
      r_we_q   <= 1'b0;
      r_we_qq  <= 1'b0;
      r_v_ack  <= 1'b0;
      r_c_ack  <= 1'b0;
      r_v_do   <= '0;
      r_c_do   <= '0;
    end else begin
      r_m_a    <= w_m_a;
      r_m_di   <= w_m_di;
      r_m_nce  <= ~w_m_ce;
      r_m_nwe  <= ~w_m_we;
      r_gnt_q  <= w_gnt;
      r_we_q   <= w_we;
      r_gnt_qq <= r_gnt_q;
      r_we_qq  <= r_we_q;
      r_v_ack  <= (r_gnt_qq == VGNT_VID) || (r_gnt_qq == VGNT_CLR);
      r_c_ack  <= (r_gnt_qq == VGNT_CPU);
      if (r_gnt_qq == VGNT_CLR) begin
        r_v_do <= CLR_VAL;
      end else if ((r_gnt_qq == VGNT_VID) && !r_we_qq) begin
        r_v_do <= M_DO;
      end
      if ((r_gnt_qq == VGNT_CPU) && !r_we_qq) begin
        r_c_do <= M_DO;
      end
    end
  end

  assign M_A      = r_m_a;
  assign M_DI     = r_m_di;
  assign M_nCE    = r_m_nce;
  assign M_nWE    = r_m_nwe;
  assign V_ACK    = r_v_ack;
  assign V_DO     = r_v_do;
  assign C_ACK    = r_c_ack;
  assign C_DO     = r_c_do;
  assign C_WAIT   = C_REQ & ~r_c_ack;
  assign CLR_BUSY = r_clr_busy;

endmodule

// File: tb/tb_vram_arb.sv
// Self-checking bench for vram_arb: directed table, hand-written corner
// sequences, then randomized traffic against a transaction-level model.
module tb_vram_arb;

  localparam int         AW   = 4;
  localparam int         DW   = 8;
  localparam int         MAXW = 2;
  localparam logic [7:0] CLRV = 8'h00;

  logic          CLK = 1'b0;
  logic          RESB = 1'b0;
  logic          CE = 1'b0, V_REQ = 1'b0, V_WE = 1'b0;
  logic [AW-1:0] V_A = '0;
  logic [DW-1:0] V_DI = '0;
  logic [DW-1:0] V_DO;
  logic          V_ACK;
  logic          C_REQ = 1'b0, C_WE = 1'b0;
  logic [AW-1:0] C_A = '0;
  logic [DW-1:0] C_DI = '0;
  logic [DW-1:0] C_DO;
  logic          C_ACK, C_WAIT;
  logic [AW-1:0] M_A;
  logic [DW-1:0] M_DI, M_DO;
  logic          M_nCE, M_nWE;
  logic          CLR_START = 1'b0;
  logic          CLR_BUSY;

  vram_arb #(.AW(AW), .DW(DW), .CLR_VAL(CLRV), .CPU_MAXWAIT(MAXW)) dut (
    .CLK(CLK), .RESB(RESB), .CE(CE),
    .V_REQ(V_REQ), .V_WE(V_WE), .V_A(V_A), .V_DI(V_DI), .V_DO(V_DO), .V_ACK(V_ACK),
    .C_REQ(C_REQ), .C_WE(C_WE), .C_A(C_A), .C_DI(C_DI), .C_DO(C_DO), .C_ACK(C_ACK),
    .C_WAIT(C_WAIT), .M_A(M_A), .M_DI(M_DI), .M_DO(M_DO), .M_nCE(M_nCE), .M_nWE(M_nWE),
    .CLR_START(CLR_START), .CLR_BUSY(CLR_BUSY)
  );

  always #5 CLK = ~CLK;

  // Single-port RAM with registered read, plus backdoor fill/write for setup.
  logic [7:0]    mem [16];
  logic          bd_fill = 1'b0, bd_wr = 1'b0;
  logic [AW-1:0] bd_a = '0;
  logic [7:0]    bd_d = '0;
  always @(posedge CLK) begin
    if (!M_nCE) begin
      if (!M_nWE) mem[M_A] <= M_DI;
      M_DO <= mem[M_A];
    end
    if (bd_wr) mem[bd_a] <= bd_d;
    if (bd_fill) for (int i = 0; i < 16; i++) mem[i] <= 8'hC3;
  end

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] last_v = 8'h00;
  logic [7:0] last_c = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check_clear();
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("clr_addr", int'(M_A), k - 1);
      chk("clr_nce", int'(M_nCE), 0);
      chk("clr_nwe", int'(M_nWE), 0);
      chk("clr_di", int'(M_DI), int'(CLRV));
      chk("clr_busy", int'(CLR_BUSY), (k < 16) ? 1 : 0);
      chk("clr_vack", int'(V_ACK), 0);
      chk("clr_cack", int'(C_ACK), 0);
      chk("clr_cwait", int'(C_WAIT), int'(C_REQ));
    end
  endtask

  typedef struct {
    bit         is_cpu;
    bit         we;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } txn_t;

  task automatic do_txn(input int idx, input txn_t t);
    int         n;
    bit         got;
    logic [7:0] do_exp;
    int         do_act;
    if (t.is_cpu) begin
      C_REQ = 1'b1; C_WE = t.we; C_A = t.a; C_DI = t.d;
    end else begin
      V_REQ = 1'b1; CE = 1'b1; V_WE = t.we; V_A = t.a; V_DI = t.d;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 8) begin
      tick();
      n++;
      if (n == 1) begin
        chk("tx_m_a", int'(M_A), int'(t.a));
        chk("tx_nce", int'(M_nCE), 0);
        chk("tx_nwe", int'(M_nWE), t.we ? 0 : 1);
        if (t.we) chk("tx_m_di", int'(M_DI), int'(t.d));
        V_REQ = 1'b0;
        CE = 1'b0;
      end
      got = t.is_cpu ? C_ACK : V_ACK;
      if (t.is_cpu) chk("tx_c_wait", int'(C_WAIT), got ? 0 : 1);
    end
    C_REQ = 1'b0;
    chk("tx_latency", n, 3);
    if (t.is_cpu) begin
      if (!t.we) last_c = t.exp;
      do_exp = last_c;
      do_act = int'(C_DO);
    end else begin
      if (!t.we) last_v = t.exp;
      do_exp = last_v;
      do_act = int'(V_DO);
    end
    chk("tx_do", do_act, int'(do_exp));
    $display("txn %0d %s %s a=%0h d=%0h do=%0h lat=%0d", idx, t.is_cpu ? "cpu" : "vid",
             t.we ? "wr" : "rd", t.a, t.d, do_act, n);
    tick();
    chk("tx_ack_pulse", int'(t.is_cpu ? C_ACK : V_ACK), 0);
  endtask

  typedef struct {
    int         due;
    bit         is_cpu;
    bit         we;
    logic [7:0] d;
  } exp_t;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t       tbl[10];
    int         nz;
    int         n;
    bit         got;
    exp_t       q[$];
    logic [7:0] ref_mem[16];
    int         edge_n;
    bit         cpu_req, cpu_gnt;
    int         cpu_lost;

    tbl[0] = '{1'b1, 1'b0, 4'd3,  8'h00, 8'h5A};
    tbl[1] = '{1'b1, 1'b1, 4'd7,  8'hA5, 8'h00};
    tbl[2] = '{1'b1, 1'b0, 4'd7,  8'h00, 8'hA5};
    tbl[3] = '{1'b0, 1'b1, 4'd0,  8'h3C, 8'h00};
    tbl[4] = '{1'b1, 1'b0, 4'd0,  8'h00, 8'h3C};
    tbl[5] = '{1'b1, 1'b1, 4'd15, 8'hEE, 8'h00};
    tbl[6] = '{1'b0, 1'b0, 4'd15, 8'h00, 8'hEE};
    tbl[7] = '{1'b0, 1'b0, 4'd3,  8'h00, 8'h5A};
    tbl[8] = '{1'b1, 1'b1, 4'd3,  8'hFF, 8'h00};
    tbl[9] = '{1'b0, 1'b0, 4'd3,  8'h00, 8'hFF};

    // Reset state, then the power-up clear over a garbage-filled RAM.
    RESB = 1'b0;
    bd_fill = 1'b1;
    tick();
    tick();
    bd_fill = 1'b0;
    tick();
    chk("rst_nce", int'(M_nCE), 1);
    chk("rst_nwe", int'(M_nWE), 1);
    chk("rst_m_a", int'(M_A), 0);
    chk("rst_m_di", int'(M_DI), 0);
    chk("rst_vack", int'(V_ACK), 0);
    chk("rst_cack", int'(C_ACK), 0);
    chk("rst_vdo", int'(V_DO), 0);
    chk("rst_cdo", int'(C_DO), 0);
    chk("rst_busy", int'(CLR_BUSY), 1);
    RESB = 1'b1;
    check_clear();
    tick();
    nz = 0;
    for (int i = 0; i < 16; i++) if (mem[i] != CLRV) nz++;
    chk("clear_fill", nz, 0);

    bd_wr = 1'b1; bd_a = 4'd3; bd_d = 8'h5A;
    tick();
    bd_wr = 1'b0;

    for (int i = 0; i < 10; i++) do_txn(i, tbl[i]);

    // Simultaneous video and CPU with an empty wait counter.
    V_REQ = 1'b1; CE = 1'b1; V_WE = 1'b0; V_A = 4'd0;
    C_REQ = 1'b1; C_WE = 1'b0; C_A = 4'd15;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) begin chk("sim_m_a_vid", int'(M_A), 0); V_REQ = 1'b0; CE = 1'b0; end
      if (k == 2) begin chk("sim_m_a_cpu", int'(M_A), 15); chk("sim_nce", int'(M_nCE), 0); end
      chk("sim_vack", int'(V_ACK), (k == 3) ? 1 : 0);
      chk("sim_cack", int'(C_ACK), (k == 4) ? 1 : 0);
      if (k == 3) chk("sim_vdo", int'(V_DO), 8'h3C);
      if (k == 4) begin chk("sim_cdo", int'(C_DO), 8'hEE); C_REQ = 1'b0; end
    end
    $display("txn sim: video then cpu");

    // CPU starvation limit: third consecutive video request loses.
    C_REQ = 1'b1; C_WE = 1'b0; C_A = 4'd0;
    V_REQ = 1'b1; CE = 1'b1; V_WE = 1'b0; V_A = 4'd7;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) begin chk("stv_m_a1", int'(M_A), 7); V_A = 4'd15; end
      if (k == 2) begin chk("stv_m_a2", int'(M_A), 15); V_A = 4'd3; end
      if (k == 3) begin chk("stv_m_a_cpu", int'(M_A), 0); V_REQ = 1'b0; CE = 1'b0; end
      chk("stv_vack", int'(V_ACK), (k == 3 || k == 4) ? 1 : 0);
      chk("stv_cack", int'(C_ACK), (k == 5) ? 1 : 0);
      if (k == 3) chk("stv_vdo1", int'(V_DO), 8'hA5);
      if (k == 4) chk("stv_vdo2", int'(V_DO), 8'hEE);
      if (k == 5) begin chk("stv_cdo", int'(C_DO), 8'h3C); C_REQ = 1'b0; end
    end
    $display("txn starve: cpu wins third cycle");

    // CLR_START with a CPU read in flight, video during clear, reset mid-clear.
    C_REQ = 1'b1; C_WE = 1'b0; C_A = 4'd3;
    tick();
    chk("cs_m_a", int'(M_A), 3);
    CLR_START = 1'b1;
    tick();
    chk("cs_idle_nce", int'(M_nCE), 1);
    chk("cs_busy", int'(CLR_BUSY), 1);
    CLR_START = 1'b0;
    tick();
    chk("cs_cack", int'(C_ACK), 1);
    chk("cs_cdo", int'(C_DO), 8'hFF);
    chk("cs_clr_a0", int'(M_A), 0);
    chk("cs_clr_nwe", int'(M_nWE), 0);
    C_REQ = 1'b0;
    V_REQ = 1'b1; CE = 1'b1; V_WE = 1'b0; V_A = 4'd5;
    tick();
    chk("cs_clr_a1", int'(M_A), 1);
    chk("cs_vack_early", int'(V_ACK), 0);
    V_REQ = 1'b0; CE = 1'b0;
    tick();
    tick();
    chk("cs_vack", int'(V_ACK), 1);
    chk("cs_vdo", int'(V_DO), int'(CLRV));
    chk("cs_clr_a3", int'(M_A), 3);
    C_REQ = 1'b1; C_WE = 1'b1; C_A = 4'd9; C_DI = 8'h77;
    tick();
    chk("cs_cwait", int'(C_WAIT), 1);
    chk("cs_cack_held", int'(C_ACK), 0);
    chk("cs_clr_a4", int'(M_A), 4);
    $display("txn clr_start: cpu ack kept, clear running");
    RESB = 1'b0;
    #1;
    chk("mr_m_a", int'(M_A), 0);
    chk("mr_nce", int'(M_nCE), 1);
    chk("mr_busy", int'(CLR_BUSY), 1);
    @(negedge CLK);
    RESB = 1'b1;
    last_v = 8'h00;
    last_c = 8'h00;
    check_clear();
    n = 0;
    got = 1'b0;
    while (!got && n < 6) begin
      tick();
      n++;
      got = C_ACK;
    end
    chk("mr_cpu_lat", n, 3);
    chk("mr_cdo_hold", int'(C_DO), 0);
    C_REQ = 1'b0;
    tick();
    nz = 0;
    for (int i = 0; i < 16; i++) if (mem[i] != ((i == 9) ? 8'h77 : CLRV)) nz++;
    chk("mr_mem", nz, 0);
    $display("txn reset_mid_clear: restart at 0, held cpu write served");

    // Randomized traffic against a transaction-level model.
    for (int i = 0; i < 16; i++) ref_mem[i] = (i == 9) ? 8'h77 : 8'h00;
    edge_n = 0;
    cpu_req = 1'b0;
    cpu_gnt = 1'b0;
    cpu_lost = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit   ev, ec, v_el, c_el;
      exp_t e;
      ev = 1'b0;
      ec = 1'b0;
      while (q.size() > 0 && q[0].due == edge_n) begin
        e = q.pop_front();
        if (e.is_cpu) begin
          ec = 1'b1;
          if (!e.we) last_c = e.d;
        end else begin
          ev = 1'b1;
          if (!e.we) last_v = e.d;
        end
      end
      chk("rnd_vack", int'(V_ACK), int'(ev));
      chk("rnd_cack", int'(C_ACK), int'(ec));
      chk("rnd_cwait", int'(C_WAIT), int'(cpu_req && !ec));
      if (ev) chk("rnd_vdo", int'(V_DO), int'(last_v));
      if (ec) chk("rnd_cdo", int'(C_DO), int'(last_c));
      if (ec) begin
        cpu_req = 1'b0;
        cpu_gnt = 1'b0;
      end
      if (!cpu_req && cyc < 590 && $urandom_range(0, 2) != 0) begin
        cpu_req = 1'b1;
        C_WE = 1'($urandom_range(0, 1));
        C_A = 4'($urandom_range(0, 15));
        C_DI = 8'($urandom_range(0, 255));
      end
      C_REQ = cpu_req;
      V_REQ = (cyc < 590) && ($urandom_range(0, 1) == 1);
      CE = ($urandom_range(0, 3) != 0);
      V_WE = 1'($urandom_range(0, 1));
      V_A = 4'($urandom_range(0, 15));
      V_DI = 8'($urandom_range(0, 255));
      v_el = V_REQ && CE;
      c_el = cpu_req && !cpu_gnt && !ec;
      if (c_el && (!v_el || cpu_lost >= MAXW)) begin
        cpu_gnt = 1'b1;
        cpu_lost = 0;
        q.push_back('{edge_n + 3, 1'b1, C_WE, ref_mem[C_A]});
        if (C_WE) ref_mem[C_A] = C_DI;
      end else if (v_el) begin
        q.push_back('{edge_n + 3, 1'b0, V_WE, ref_mem[V_A]});
        if (V_WE) ref_mem[V_A] = V_DI;
        if (c_el) cpu_lost++;
      end
      tick();
      edge_n++;
    end
    $display("txn random: %0d cycles", edge_n);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
